sp1_ram_copier: RTL

Bus-master engine that drives the sp1_ram single-port interface (cs/we/adrs/din/dout) to perform block operations without CPU involvement. It supports two operations: COPY moves len words from src to dst, and FILL writes a constant pattern to len words starting at dst. The block sits between a control source (sequencer or CPU register block), which uses a start/busy/done handshake, and one sp1_ram instance whose port it owns while busy.

---
 rtl/sp1_ram_copier.sv | 76 +++++++
 1 files changed

// File: rtl/sp1_ram_copier.sv
// sp1_ram_copier: COPY/FILL block engine; start/op/src/dst/len/pattern in, busy/done out, owns sp1_ram port cs/we/adrs/din with dout back
module sp1_ram_copier #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int DS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic          cs,
  output logic          we,
  output logic [AW-1:0] adrs,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] dout
);
  localparam int CW = $clog2(DS + 1) > AW + 1 ? $clog2(DS + 1) : AW + 1;
  localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, WR = 3'd2, FIL = 3'd3, FIN = 3'd4;
  logic [2:0]    state_q, state_d;
  logic          op_q, op_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] pat_q, pat_d;
  logic [CW-1:0] i_q, i_d, i_nx;
  always_comb begin
    {op_d, src_d, dst_d, len_d, pat_d} = {op_q, src_q, dst_q, len_q, pat_q};
    i_d = i_q;
    state_d = state_q;
    i_nx = i_q + 1'b1;
    if (state_q == IDLE && start) begin
      {op_d, src_d, dst_d, len_d, pat_d} = {op, src, dst, len, pattern};
      i_d = '0;
      state_d = len == '0 ? FIN : op ? FIL : RD;
    end else if (state_q == RD) begin
      state_d = WR;
    end else if (state_q == WR || state_q == FIL) begin
      i_d = i_nx;
      state_d = i_nx == CW'(len_q) ? FIN : op_q ? FIL : RD;
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      pat_q <= '0;
      i_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      pat_q <= pat_d;
      i_q <= i_d;
    end
  end
  always_comb begin
    busy = state_q == RD || state_q == WR || state_q == FIL;
    done = state_q == FIN;
    cs = busy;
    we = state_q == WR || state_q == FIL;
    adrs = state_q == RD ? src_q + i_q[AW-1:0] : we ? dst_q + i_q[AW-1:0] : '0;
    din = state_q == WR ? dout : state_q == FIL ? pat_q : '0;
  end
endmodule
